aurora_link_mgr: RTL and testbench

Parametrised N-channel Aurora link bring-up and supervision controller, the successor to the fixed two-port boot sequencing used by the dual-port Aurora wrapper. It drives the shared `RESET_PB`/`PMA_INIT` sequence for one master core and NCH-1 slave cores. It debounces each core's `channel_up` and flags link drops. It retrains the whole group on timeout, link loss or software request. It runs on the init clock domain and sits beside the per-port `aurora_port_axi` instances.

---
 rtl/aurora_link_mgr.sv | 224 ++++++++++++++++++++++
 tb/tb_aurora_link_mgr.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_link_mgr.sv
// aurora_link_mgr
// ---------------------------------------------------------------------------
// Bring-up and supervision controller for a group of NCH Aurora cores (one
// master plus NCH-1 slaves) sharing one RESET_PB / PMA_INIT sequence. It runs
// on the init clock. It debounces every core's channel_up, flags link drops,
// and retrains the whole group after a timeout, a link loss or a software
// request.
//
// Build option:
//   AURORA_LINK_MGR_AUTORETRY_EN - when defined, a WAIT_UP timeout or a RUN
//   link loss restarts the sequence directly. When undefined, both events
//   park the FSM in FAIL until RETRAIN_REQ is asserted or lock is lost.
//
// Ports:
//   CLK          in   init clock
//   SYS_RST_N    in   asynchronous active-low reset
//   DCM_LOCKED   in   clock-manager lock (async, 2-flop synchronised)
//   CH_UP        in   per-core channel_up, NCH bits (async, 2-flop per bit)
//   RETRAIN_REQ  in   retrain request level, honoured in RUN or FAIL
//   RESET_PB     out  master core reset_pb
//   PMA_INIT     out  master core pma_init
//   LINK_OK      out  debounced channel status, NCH bits
//   DOWN_EVT     out  one-cycle pulse per LINK_OK fall, NCH bits
//   ALL_UP       out  high only while in RUN
//   RETRY_CNT    out  saturating restart count, 8 bits
//   STATE        out  FSM state encoding, 3 bits
// ---------------------------------------------------------------------------
module aurora_link_mgr #(
  parameter int             NCH        = 2,
  parameter logic [NCH-1:0] CH_MASK    = {NCH{1'b1}},
  parameter int             PB_CYCLES  = 128,
  parameter int             PMA_CYCLES = 1024,
  parameter int             DEB_CYCLES = 16,
  parameter int             UP_TIMEOUT = 1000000
) (
  input  logic             CLK,
  input  logic             SYS_RST_N,
  input  logic             DCM_LOCKED,
  input  logic [NCH-1:0]   CH_UP,
  input  logic             RETRAIN_REQ,
  output logic             RESET_PB,
  output logic             PMA_INIT,
  output logic [NCH-1:0]   LINK_OK,
  output logic [NCH-1:0]   DOWN_EVT,
  output logic             ALL_UP,
  output logic [7:0]       RETRY_CNT,
  output logic [2:0]       STATE
);

  localparam int MAX_A = (PB_CYCLES > PMA_CYCLES) ? PB_CYCLES : PMA_CYCLES;
  localparam int MAX_B = (MAX_A > UP_TIMEOUT) ? MAX_A : UP_TIMEOUT;
  localparam int MAX_T = (MAX_B > DEB_CYCLES) ? MAX_B : DEB_CYCLES;
  localparam int CW    = $clog2(MAX_T) + 1;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_PB_PRE    = 3'd1,
    ST_PMA       = 3'd2,
    ST_PB_POST   = 3'd3,
    ST_WAIT_UP   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAIL      = 3'd6
  } state_t;

  // Synchronisers
  logic           lock_meta_reg, lock_sync_reg;
  logic [NCH-1:0] ch_meta_reg, ch_sync_reg;

  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
      ch_meta_reg   <= '0;
      ch_sync_reg   <= '0;
    end else begin
      lock_meta_reg <= DCM_LOCKED;
      lock_sync_reg <= lock_meta_reg;
      ch_meta_reg   <= CH_UP;
      ch_sync_reg   <= ch_meta_reg;
    end
  end

  // Per-channel debounce: LINK_OK follows ch_sync only after DEB_CYCLES
  // consecutive cycles of disagreement; any agreeing cycle clears the count.
  logic [NCH-1:0] link_ok_reg, link_ok_next, link_ok_d_reg, down_evt_reg;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_deb
    logic [CW-1:0] deb_cnt_reg;
    logic          deb_diff;
    logic          deb_done;

    assign deb_diff = (ch_sync_reg[gi] != link_ok_reg[gi]);
    assign deb_done = deb_diff && (deb_cnt_reg == CW'(DEB_CYCLES - 1));
    assign link_ok_next[gi] = deb_done ? ch_sync_reg[gi] : link_ok_reg[gi];

    always_ff @(posedge CLK or negedge SYS_RST_N) begin
      if (!SYS_RST_N)
        deb_cnt_reg <= '0;
      else if (!deb_diff || deb_done)
        deb_cnt_reg <= '0;
      else
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
    end
  end

  // DOWN_EVT is produced one cycle after the LINK_OK fall, which lines it
  // up with the FSM reacting to that fall.
  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      link_ok_reg   <= '0;
      link_ok_d_reg <= '0;
      down_evt_reg  <= '0;
    end else begin
      link_ok_reg   <= link_ok_next;
      link_ok_d_reg <= link_ok_reg;
      down_evt_reg  <= link_ok_d_reg & ~link_ok_reg;
    end
  end

  // FSM
  state_t        state_reg, state_next;
  logic [CW-1:0] timer_reg, timer_next;
  logic          restart;
  logic          all_masked_up;
  logic          reset_pb_reg, reset_pb_next;
  logic          pma_init_reg, pma_init_next;
  logic          all_up_reg, all_up_next;
  logic [7:0]    retry_reg;

  assign all_masked_up = &(link_ok_reg | ~CH_MASK);

  always_comb begin
    state_next = state_reg;
    restart    = 1'b0;
    if (!lock_sync_reg) begin
      state_next = ST_WAIT_LOCK;
    end else begin
      case (state_reg)
        ST_WAIT_LOCK: state_next = ST_PB_PRE;
        ST_PB_PRE:
          if (timer_reg == CW'(PB_CYCLES - 1)) state_next = ST_PMA;
        ST_PMA:
          if (timer_reg == CW'(PMA_CYCLES - 1)) state_next = ST_PB_POST;
        ST_PB_POST:
          if (timer_reg == CW'(PB_CYCLES - 1)) state_next = ST_WAIT_UP;
        ST_WAIT_UP:
          if (all_masked_up) begin
            state_next = ST_RUN;
          end else if (timer_reg == CW'(UP_TIMEOUT - 1)) begin
`ifdef AURORA_LINK_MGR_AUTORETRY_EN
            state_next = ST_PB_PRE;
            restart    = 1'b1;
`else
            state_next = ST_FAIL;
`endif
          end
        ST_RUN:
          // A request and a simultaneous drop collapse into one restart.
          if (RETRAIN_REQ) begin
            state_next = ST_PB_PRE;
            restart    = 1'b1;
          end else if (!all_masked_up) begin
`ifdef AURORA_LINK_MGR_AUTORETRY_EN
            state_next = ST_PB_PRE;
            restart    = 1'b1;
`else
            state_next = ST_FAIL;
`endif
          end
        ST_FAIL:
          if (RETRAIN_REQ) begin
            state_next = ST_PB_PRE;
            restart    = 1'b1;
          end
        default: state_next = ST_WAIT_LOCK;
      endcase
    end
  end

  // Phase timer counts cycles spent in the current timed state.
  always_comb begin
    timer_next = '0;
    if (state_next == state_reg &&
        (state_reg == ST_PB_PRE || state_reg == ST_PMA ||
         state_reg == ST_PB_POST || state_reg == ST_WAIT_UP))
      timer_next = timer_reg + 1'b1;
  end

  // Outputs are decoded from the next state so they register with STATE.
  always_comb begin
    reset_pb_next = (state_next == ST_WAIT_LOCK) || (state_next == ST_PB_PRE) ||
                    (state_next == ST_PMA) || (state_next == ST_PB_POST);
    pma_init_next = (state_next == ST_WAIT_LOCK) || (state_next == ST_PMA);
    all_up_next   = (state_next == ST_RUN);
  end

  always_ff @(posedge CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_reg    <= ST_WAIT_LOCK;
      timer_reg    <= '0;
      reset_pb_reg <= 1'b1;
      pma_init_reg <= 1'b1;
      all_up_reg   <= 1'b0;
      retry_reg    <= 8'd0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      reset_pb_reg <= reset_pb_next;
      pma_init_reg <= pma_init_next;
      all_up_reg   <= all_up_next;
      if (restart && retry_reg != 8'hFF)
        retry_reg <= retry_reg + 8'd1;
    end
  end

  assign RESET_PB  = reset_pb_reg;
  assign PMA_INIT  = pma_init_reg;
  assign LINK_OK   = link_ok_reg;
  assign DOWN_EVT  = down_evt_reg;
  assign ALL_UP    = all_up_reg;
  assign RETRY_CNT = retry_reg;
  assign STATE     = state_reg;

endmodule

// File: tb/tb_aurora_link_mgr.sv
// tb_aurora_link_mgr
// Directed bench for aurora_link_mgr with NCH=2, PB=4, PMA=8, DEB=3,
// UP_TIMEOUT=50. A second instance with CH_MASK=2'b01 covers masking.
// Expected behaviour follows both settings of AURORA_LINK_MGR_AUTORETRY_EN.
module tb_aurora_link_mgr;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic [1:0] ch_up;
  logic       req;
  logic       rst_pb, pma;
  logic [1:0] link_ok, down_evt;
  logic       all_up;
  logic [7:0] retry;
  logic [2:0] state;

  logic       lock_m;
  logic [1:0] ch_up_m;
  logic       req_m;
  logic       rst_pb_m, pma_m;
  logic [1:0] link_ok_m, down_evt_m;
  logic       all_up_m;
  logic [7:0] retry_m;
  logic [2:0] state_m;

  int checks = 0;
  int errors = 0;

  aurora_link_mgr #(
    .NCH(2), .CH_MASK(2'b11), .PB_CYCLES(4), .PMA_CYCLES(8),
    .DEB_CYCLES(3), .UP_TIMEOUT(50)
  ) dut (
    .CLK(clk), .SYS_RST_N(rst_n), .DCM_LOCKED(lock), .CH_UP(ch_up),
    .RETRAIN_REQ(req), .RESET_PB(rst_pb), .PMA_INIT(pma), .LINK_OK(link_ok),
    .DOWN_EVT(down_evt), .ALL_UP(all_up), .RETRY_CNT(retry), .STATE(state)
  );

  aurora_link_mgr #(
    .NCH(2), .CH_MASK(2'b01), .PB_CYCLES(4), .PMA_CYCLES(8),
    .DEB_CYCLES(3), .UP_TIMEOUT(50)
  ) dut_m (
    .CLK(clk), .SYS_RST_N(rst_n), .DCM_LOCKED(lock_m), .CH_UP(ch_up_m),
    .RETRAIN_REQ(req_m), .RESET_PB(rst_pb_m), .PMA_INIT(pma_m), .LINK_OK(link_ok_m),
    .DOWN_EVT(down_evt_m), .ALL_UP(all_up_m), .RETRY_CNT(retry_m), .STATE(state_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (rst_pb !== 1'b1 || pma !== 1'b1) begin errors++; $display("FAIL reset_outs: reset_pb %b pma_init %b want 1 1", rst_pb, pma); end
    checks++; if (link_ok !== 2'b00 || down_evt !== 2'b00) begin errors++; $display("FAIL reset_link: link_ok %b down_evt %b want 00 00", link_ok, down_evt); end
    checks++; if (all_up !== 1'b0 || retry !== 8'd0) begin errors++; $display("FAIL reset_misc: all_up %b retry %0d want 0 0", all_up, retry); end
    $display("test_reset done");
  endtask

  // Reset released just after an edge; edges below are counted from there.
  task automatic test_bringup;
    rst_n = 1'b1;
    tick(2);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL lock_sync_delay: state %0d want 0", state); end
    tick(1);  // edge 3
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL pb_pre_entry: state %0d want 1", state); end
    tick(11); // edge 14
    checks++; if (state !== 3'd2 || pma !== 1'b1) begin errors++; $display("FAIL pma_hold: state %0d pma_init %b want 2 1", state, pma); end
    tick(1);  // edge 15
    checks++; if (state !== 3'd3 || pma !== 1'b0 || rst_pb !== 1'b1) begin errors++; $display("FAIL pb_post: state %0d pma_init %b reset_pb %b want 3 0 1", state, pma, rst_pb); end
    tick(3);  // edge 18
    checks++; if (rst_pb !== 1'b1) begin errors++; $display("FAIL pb_post_hold: reset_pb %b want 1", rst_pb); end
    tick(1);  // edge 19
    checks++; if (state !== 3'd4 || rst_pb !== 1'b0 || pma !== 1'b0) begin errors++; $display("FAIL wait_up: state %0d reset_pb %b pma_init %b want 4 0 0", state, rst_pb, pma); end
    checks++; if (state_m !== 3'd4) begin errors++; $display("FAIL mask_wait_up: state %0d want 4", state_m); end
    $display("test_bringup done");
  endtask

  task automatic test_link_up;
    ch_up = 2'b11;
    tick(1);  // edge 20
    checks++; if (state_m !== 3'd5 || all_up_m !== 1'b1) begin errors++; $display("FAIL mask_already_up: state %0d all_up %b want 5 1", state_m, all_up_m); end
    tick(3);
    checks++; if (link_ok !== 2'b00) begin errors++; $display("FAIL deb_early: link_ok %b want 00", link_ok); end
    tick(1);
    checks++; if (link_ok !== 2'b11 || all_up !== 1'b0 || state !== 3'd4) begin errors++; $display("FAIL deb_rise: link_ok %b all_up %b state %0d want 11 0 4", link_ok, all_up, state); end
    tick(1);
    checks++; if (all_up !== 1'b1 || state !== 3'd5 || retry !== 8'd0) begin errors++; $display("FAIL run_entry: all_up %b state %0d retry %0d want 1 5 0", all_up, state, retry); end
    $display("test_link_up done");
  endtask

  task automatic test_mask;
    checks++; if (link_ok_m !== 2'b01 || retry_m !== 8'd0) begin errors++; $display("FAIL mask_run: link_ok %b retry %0d want 01 0", link_ok_m, retry_m); end
    ch_up_m = 2'b11;
    tick(5);
    checks++; if (link_ok_m !== 2'b11) begin errors++; $display("FAIL mask_rise: link_ok %b want 11", link_ok_m); end
    ch_up_m = 2'b01;
    tick(5);
    checks++; if (link_ok_m !== 2'b01 || down_evt_m !== 2'b00) begin errors++; $display("FAIL mask_fall: link_ok %b down_evt %b want 01 00", link_ok_m, down_evt_m); end
    tick(1);
    checks++; if (down_evt_m !== 2'b10 || state_m !== 3'd5 || retry_m !== 8'd0) begin errors++; $display("FAIL mask_down_evt: down_evt %b state %0d retry %0d want 10 5 0", down_evt_m, state_m, retry_m); end
    $display("test_mask done");
  endtask

  task automatic test_glitch;
    ch_up = 2'b01;
    tick(2);
    ch_up = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++; if (link_ok !== 2'b11 || down_evt !== 2'b00 || state !== 3'd5) begin errors++; $display("FAIL short_glitch: link_ok %b down_evt %b state %0d want 11 00 5", link_ok, down_evt, state); end
    end
    ch_up = 2'b01;
    tick(4);
    ch_up = 2'b11;
    checks++; if (link_ok !== 2'b11) begin errors++; $display("FAIL drop_early: link_ok %b want 11", link_ok); end
    tick(1);
    checks++; if (link_ok !== 2'b01 || state !== 3'd5 || down_evt !== 2'b00) begin errors++; $display("FAIL drop_fall: link_ok %b state %0d down_evt %b want 01 5 00", link_ok, state, down_evt); end
    tick(1);
`ifdef AURORA_LINK_MGR_AUTORETRY_EN
    checks++; if (down_evt !== 2'b10 || state !== 3'd1 || retry !== 8'd1) begin errors++; $display("FAIL drop_restart: down_evt %b state %0d retry %0d want 10 1 1", down_evt, state, retry); end
`else
    checks++; if (down_evt !== 2'b10 || state !== 3'd6 || retry !== 8'd0) begin errors++; $display("FAIL drop_fail: down_evt %b state %0d retry %0d want 10 6 0", down_evt, state, retry); end
    req = 1'b1;
    tick(1);
    req = 1'b0;
    checks++; if (state !== 3'd1 || retry !== 8'd1) begin errors++; $display("FAIL fail_retrain: state %0d retry %0d want 1 1", state, retry); end
`endif
    tick(1);
    checks++; if (down_evt !== 2'b00) begin errors++; $display("FAIL down_evt_width: down_evt %b want 00", down_evt); end
    $display("test_glitch done");
  endtask

  task automatic test_timeout;
    int n;
    ch_up = 2'b00;
    n = 0;
    while (state !== 3'd4 && n < 100) begin tick(1); n++; end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL timeout_wait_up: state %0d want 4 after %0d cycles", state, n); end
    tick(49);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL timeout_early: state %0d want 4", state); end
    tick(1);
`ifdef AURORA_LINK_MGR_AUTORETRY_EN
    checks++; if (state !== 3'd1 || retry !== 8'd2) begin errors++; $display("FAIL timeout_restart: state %0d retry %0d want 1 2", state, retry); end
`else
    checks++; if (state !== 3'd6 || retry !== 8'd1) begin errors++; $display("FAIL timeout_fail: state %0d retry %0d want 6 1", state, retry); end
    tick(3);
    checks++; if (state !== 3'd6) begin errors++; $display("FAIL fail_hold: state %0d want 6", state); end
`endif
    req = 1'b1;
    tick(1);
    checks++; if (state !== 3'd1 || retry !== 8'd2) begin errors++; $display("FAIL retrain_req: state %0d retry %0d want 1 2", state, retry); end
    tick(1);
    req = 1'b0;
    checks++; if (state !== 3'd1 || retry !== 8'd2) begin errors++; $display("FAIL req_ignored: state %0d retry %0d want 1 2", state, retry); end
    $display("test_timeout done");
  endtask

  task automatic test_lock_loss;
    int n;
    n = 0;
    while (state !== 3'd2 && n < 100) begin tick(1); n++; end
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL lock_pma_wait: state %0d want 2", state); end
    tick(2);
    lock = 1'b0;
    tick(2);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL lock_loss_early: state %0d want 2", state); end
    tick(1);
    checks++; if (state !== 3'd0 || rst_pb !== 1'b1 || pma !== 1'b1 || retry !== 8'd2) begin errors++; $display("FAIL lock_loss: state %0d reset_pb %b pma_init %b retry %0d want 0 1 1 2", state, rst_pb, pma, retry); end
    tick(5);
    lock = 1'b1;
    tick(2);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL relock_early: state %0d want 0", state); end
    tick(1);
    checks++; if (state !== 3'd1 || retry !== 8'd2) begin errors++; $display("FAIL relock: state %0d retry %0d want 1 2", state, retry); end
    $display("test_lock_loss done");
  endtask

  task automatic test_simultaneous;
    int n;
    ch_up = 2'b11;
    n = 0;
    while (state !== 3'd5 && n < 100) begin tick(1); n++; end
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL simul_run: state %0d want 5", state); end
    ch_up = 2'b10;
    tick(4);
    checks++; if (link_ok !== 2'b11) begin errors++; $display("FAIL simul_early: link_ok %b want 11", link_ok); end
    tick(1);
    checks++; if (link_ok !== 2'b10 || state !== 3'd5) begin errors++; $display("FAIL simul_fall: link_ok %b state %0d want 10 5", link_ok, state); end
    req = 1'b1;
    tick(1);
    req = 1'b0;
    ch_up = 2'b11;
    checks++; if (state !== 3'd1 || retry !== 8'd3 || down_evt !== 2'b01) begin errors++; $display("FAIL simul_restart: state %0d retry %0d down_evt %b want 1 3 01", state, retry, down_evt); end
    tick(1);
    checks++; if (retry !== 8'd3) begin errors++; $display("FAIL simul_single: retry %0d want 3", retry); end
    $display("test_simultaneous done");
  endtask

  task automatic test_saturation;
    int n;
    int exp_retry;
    exp_retry = 3;
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (state !== 3'd5 && n < 100) begin tick(1); n++; end
      if (state !== 3'd5) begin
        checks++; errors++;
        $display("FAIL sat_run_wait: state %0d want 5 at retrain %0d", state, i);
        break;
      end
      req = 1'b1;
      tick(1);
      req = 1'b0;
      exp_retry = (exp_retry == 255) ? 255 : exp_retry + 1;
      checks++; if (retry !== exp_retry[7:0] || state !== 3'd1) begin errors++; $display("FAIL sat_step: retrain %0d retry %0d state %0d want %0d 1", i, retry, state, exp_retry); end
    end
    checks++; if (retry !== 8'd255) begin errors++; $display("FAIL sat_final: retry %0d want 255", retry); end
    lock = 1'b0;
    tick(3);
    checks++; if (state !== 3'd0 || rst_pb !== 1'b1 || pma !== 1'b1 || retry !== 8'd255) begin errors++; $display("FAIL sat_lock_loss: state %0d reset_pb %b pma_init %b retry %0d want 0 1 1 255", state, rst_pb, pma, retry); end
    $display("test_saturation done");
  endtask

  initial begin
    rst_n   = 1'b0;
    lock    = 1'b1;
    ch_up   = 2'b00;
    req     = 1'b0;
    lock_m  = 1'b1;
    ch_up_m = 2'b01;
    req_m   = 1'b0;
    tick(3);
    test_reset();
    test_bringup();
    test_link_up();
    test_mask();
    test_glitch();
    test_timeout();
    test_lock_loss();
    test_simultaneous();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
